ahb_apb_bridge: RTL

AHB-Lite slave to APB master bridge. It sits directly upstream of the APB slave interface: it accepts single AHB transfers and drives Paddr, Pwdata, Pwrite, Pselx and Penable, and it returns Prdata to the AHB side. Transfers are fixed-length APB SETUP then ENABLE. APB has no Pready, so there are no APB wait states. The bridge stalls AHB through Hreadyout and flags unmapped addresses with a two-cycle ERROR response.

---
 rtl/ahb_apb_bridge.sv | 109 ++++++++++
 1 files changed

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave to APB master bridge with fixed SETUP/ENABLE timing and ERROR on unmapped addresses
module ahb_apb_bridge #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                NSLV     = 4,
  parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE = 32'h0400_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Hreadyout,
  output logic              Hresp,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  input  logic [DATA_W-1:0] Prdata
);
  typedef enum logic [2:0] {ST_IDLE, ST_WWAIT, ST_SETUP, ST_ENABLE, ST_ERR1, ST_ERR2} state_t;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NSLV) * {1'b0, SLV_SIZE};
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic [NSLV-1:0]     pselx_q, pselx_d;
  logic [NSLV-1:0]     sel_q, sel_d;
  logic                penable_q, penable_d;
  logic                valid, hit;
  logic [ADDR_W-1:0]   off, idx;
  logic [NSLV-1:0]     sel;
  // address decode: window hit and one-hot slave select
  always_comb begin
    valid = Hreadyin && (Htrans inside {2'b10, 2'b11});
    off   = Haddr - BASE;
    idx   = off / SLV_SIZE;
    hit   = (Haddr >= BASE) && ({1'b0, off} < SPAN);
    sel   = '0;
    for (int i = 0; i < NSLV; i++) sel[i] = hit && (idx == ADDR_W'(i));
  end
  // next state and registered APB outputs; accept points are IDLE, ENABLE and ERR2
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    sel_d     = sel_q;
    pselx_d   = '0;
    penable_d = 1'b0;
    case (state_q)
      ST_WWAIT: begin
        pwdata_d = Hwdata;
        pselx_d  = sel_q;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        pselx_d   = pselx_q;
        penable_d = 1'b1;
        state_d   = ST_ENABLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (valid) begin
          paddr_d  = Haddr;
          pwrite_d = Hwrite;
          sel_d    = sel;
          pselx_d  = (!Hwrite || state_q == ST_ENABLE) ? sel : '0;
          state_d  = !hit ? ST_ERR1 : Hwrite ? ST_WWAIT : ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end
  // state and APB register bank, cleared asynchronously so selects drop at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      sel_q     <= '0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      sel_q     <= sel_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
    end
  end
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Pwrite    = pwrite_q;
  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Hreadyout = state_q inside {ST_IDLE, ST_ENABLE, ST_ERR2};
  assign Hresp     = state_q inside {ST_ERR1, ST_ERR2};
  assign Hrdata    = (state_q == ST_ENABLE && !pwrite_q) ? Prdata : '0;
endmodule
